// File: rtl/alu_src_stage.sv
// Operand-select stage: picks A/B words from a packed source bus and buffers them in a
// 2-entry in-order queue with registered outputs. Optional macro: ALU_SRC_STAGE_SEL_ERR_EN.
module alu_src_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 5,
  parameter int SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NSRC*WIDTH-1:0]   src,
  input  logic [SEL_W-1:0]        a_sel,
  input  logic [SEL_W-1:0]        b_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_a,
  output logic [WIDTH-1:0]        out_b,
  output logic [1:0]              occupancy,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   head_a_q, head_a_d;
  logic [WIDTH-1:0]   head_b_q, head_b_d;
  logic [WIDTH-1:0]   tail_a_q, tail_a_d;
  logic [WIDTH-1:0]   tail_b_q, tail_b_d;
  logic [WIDTH-1:0]   sel_a_s, sel_b_s;
  logic               in_ready_s, out_valid_s, push_s, pop_s;

  // Out-of-range selects match no word and therefore yield zero.
  function automatic logic [WIDTH-1:0] pick_word(input logic [NSRC*WIDTH-1:0] words,
                                                 input logic [SEL_W-1:0]      sel);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NSRC; i++) begin
      w = w | ({WIDTH{sel == SEL_W'(i)}} & words[i*WIDTH +: WIDTH]);
    end
    return w;
  endfunction

  assign sel_a_s     = pick_word(src, a_sel);
  assign sel_b_s     = pick_word(src, b_sel);
  assign in_ready_s  = (state_q != ST_FULL);
  assign out_valid_s = (state_q != ST_EMPTY);
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_a     = head_a_q;
  assign out_b     = head_b_q;
  assign occupancy = state_q;

  // Buffer next-state: head is always the oldest entry, tail only used in FULL.
  always_comb begin
    state_d  = state_q;
    head_a_d = head_a_q;
    head_b_d = head_b_q;
    tail_a_d = tail_a_q;
    tail_b_d = tail_b_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d  = ST_ONE;
            head_a_d = sel_a_s;
            head_b_d = sel_b_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          case ({push_s, pop_s})
            2'b11: begin
              head_a_d = sel_a_s;
              head_b_d = sel_b_s;
            end
            2'b10: begin
              state_d  = ST_FULL;
              tail_a_d = sel_a_s;
              tail_b_d = sel_b_s;
            end
            2'b01:   state_d = ST_EMPTY;
            default: state_d = ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (pop_s) begin
            state_d  = ST_ONE;
            head_a_d = tail_a_q;
            head_b_d = tail_b_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      head_a_q <= '0;
      head_b_q <= '0;
      tail_a_q <= '0;
      tail_b_q <= '0;
    end else begin
      state_q  <= state_d;
      head_a_q <= head_a_d;
      head_b_q <= head_b_d;
      tail_a_q <= tail_a_d;
      tail_b_q <= tail_b_d;
    end
  end

`ifdef ALU_SRC_STAGE_SEL_ERR_EN
  logic sel_err_q;

  function automatic logic sel_oob(input logic [SEL_W-1:0] sel);
    return (int'(sel) >= NSRC);
  endfunction

  // Sticky flag: any accepted entry carrying an out-of-range select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (push_s && (sel_oob(a_sel) || sel_oob(b_sel))) begin
      sel_err_q <= 1'b1;
    end else begin
      sel_err_q <= sel_err_q;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_src_stage.sv
// Self-checking bench for alu_src_stage: directed scenarios then randomized traffic,
// all checked against a queue-based reference model.
module tb_alu_src_stage;
  localparam int WIDTH = 32;
  localparam int NSRC  = 5;
  localparam int SEL_W = 3;

  logic                  clk = 1'b0;
  logic                  rst, flush, in_valid, out_ready;
  logic [NSRC*WIDTH-1:0] src;
  logic [SEL_W-1:0]      a_sel, b_sel;
  logic                  in_ready, out_valid, sel_err;
  logic [WIDTH-1:0]      out_a, out_b;
  logic [1:0]            occupancy;

  logic [WIDTH-1:0] words [NSRC];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  entry_t q[$];
  logic   err_m;
  logic   rst_last;
  int     n_vec = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    src = '0;
    for (int i = 0; i < NSRC; i++) src[i*WIDTH +: WIDTH] = words[i];
  end

  alu_src_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .src(src),
    .a_sel(a_sel), .b_sel(b_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .occupancy(occupancy), .sel_err(sel_err)
  );

  function automatic logic [WIDTH-1:0] ref_pick(input logic [SEL_W-1:0] sel);
    if (int'(sel) < NSRC) return words[int'(sel)];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic cycle();
    entry_t e;
    bit     do_push, do_pop;
    @(posedge clk);
    e.a = ref_pick(a_sel);
    e.b = ref_pick(b_sel);
    do_push = in_valid && (q.size() < 2);
    do_pop  = out_ready && (q.size() > 0);
    if (rst) begin
      q.delete();
      err_m = 1'b0;
    end else begin
`ifdef ALU_SRC_STAGE_SEL_ERR_EN
      if (do_push && (int'(a_sel) >= NSRC || int'(b_sel) >= NSRC)) err_m = 1'b1;
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
    end
    rst_last = rst;
    #1;
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
    chk("sel_err",   32'(sel_err),   32'(err_m));
    if (q.size() > 0) begin
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
    end else if (rst_last) begin
      chk("out_a_rst", out_a, 32'h0);
      chk("out_b_rst", out_b, 32'h0);
    end
  endtask

  task automatic drive(input logic iv, input logic [SEL_W-1:0] as, input logic [SEL_W-1:0] bs,
                       input logic ordy);
    in_valid  = iv;
    a_sel     = as;
    b_sel     = bs;
    out_ready = ordy;
  endtask

  logic exp_err;

  initial begin
    err_m = 1'b0;
    rst_last = 1'b0;
`ifdef ALU_SRC_STAGE_SEL_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < NSRC; i++) words[i] = 32'(16 * (i + 1));
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 1'b0);
    cycle();
    cycle();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", out_a, 32'h0);
    rst = 1'b0;

    // Single push, one-cycle latency
    drive(1'b1, 3'd2, 3'd4, 1'b1);
    cycle();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_a", out_a, 32'h30);
    chk("lat_b", out_b, 32'h50);
    chk("lat_occ", 32'(occupancy), 32'd1);
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    cycle();

    // Fill to FULL, third push rejected, then drain in order
    drive(1'b1, 3'd0, 3'd1, 1'b0);
    cycle();
    chk("fill1_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 3'd1, 3'd2, 1'b0);
    cycle();
    chk("fill2_ready", 32'(in_ready), 32'd0);
    chk("fill2_occ", 32'(occupancy), 32'd2);
    drive(1'b1, 3'd3, 3'd4, 1'b0);
    words[0] = 32'hdead0000;
    words[1] = 32'hbeef0000;
    cycle();
    chk("rej_occ", 32'(occupancy), 32'd2);
    chk("rej_a", out_a, 32'h10);
    chk("rej_b", out_b, 32'h20);
    for (int i = 0; i < NSRC; i++) words[i] = 32'(16 * (i + 1));
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    cycle();
    chk("pop1_occ", 32'(occupancy), 32'd1);
    chk("pop1_a", out_a, 32'h20);
    chk("pop1_b", out_b, 32'h30);
    cycle();
    chk("pop2_occ", 32'(occupancy), 32'd0);
    chk("pop2_valid", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at occupancy 1
    drive(1'b1, 3'd0, 3'd0, 1'b0);
    cycle();
    drive(1'b1, 3'd3, 3'd2, 1'b1);
    cycle();
    chk("pp_occ", 32'(occupancy), 32'd1);
    chk("pp_a", out_a, 32'h40);
    chk("pp_b", out_b, 32'h30);
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    cycle();

    // Out-of-range select yields zero and flags sel_err when enabled
    drive(1'b1, 3'd6, 3'd1, 1'b0);
    cycle();
    chk("oob_a", out_a, 32'h0);
    chk("oob_b", out_b, 32'h20);
    chk("oob_err", 32'(sel_err), 32'(exp_err));
    drive(1'b1, 3'd0, 3'd1, 1'b0);
    cycle();
    chk("oob_err_sticky", 32'(sel_err), 32'(exp_err));

    // Flush at FULL overrides push
    flush = 1'b1;
    drive(1'b1, 3'd2, 3'd2, 1'b0);
    cycle();
    flush = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);

    // Reset overrides flush and push at FULL with sel_err set
    drive(1'b1, 3'd7, 3'd7, 1'b0);
    cycle();
    cycle();
    rst = 1'b1; flush = 1'b1;
    cycle();
    rst = 1'b0; flush = 1'b0;
    chk("rst2_occ", 32'(occupancy), 32'd0);
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_a", out_a, 32'h0);
    chk("rst2_b", out_b, 32'h0);
    chk("rst2_err", 32'(sel_err), 32'd0);
    chk("rst2_ready", 32'(in_ready), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSRC; i++) words[i] = $urandom;
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_src_stage.md
ALU_SRC_STAGE -- requirements
Module: alu_src_stage

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter NSRC, default 5: number of selectable source words, range 2..2^SEL_W-1.
REQ-003 Parameter SEL_W, default 3: select field width.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port flush  input  1: synchronous discard of all buffered entries.
REQ-007 Port src  input  NSRC*WIDTH: packed sources; word i at bits [i*WIDTH +: WIDTH].
REQ-008 Port a_sel  input  SEL_W: source index for operand A.
REQ-009 Port b_sel  input  SEL_W: source index for operand B.
REQ-010 Port in_valid  input  1: upstream offers a_sel/b_sel/src this cycle.
REQ-011 Port in_ready  output  1: stage can accept an entry this cycle.
REQ-012 Port out_valid  output  1: out_a/out_b hold a valid entry.
REQ-013 Port out_ready  input  1: downstream consumes the head entry this cycle.
REQ-014 Port out_a  output  WIDTH: head entry operand A, registered.
REQ-015 Port out_b  output  WIDTH: head entry operand B, registered.
REQ-016 Port occupancy  output  2: number of buffered entries, 0..2.
REQ-017 Port sel_err  output  1: sticky out-of-range select flag (see Configuration).

Function
REQ-018 Selection SHALL be word i of src when sel < NSRC, else all-zero; A and B select independently.
REQ-019 Selected operands SHALL be captured at accept time; later src changes SHALL NOT affect buffered entries.
REQ-020 Storage SHALL be a 2-entry in-order buffer; states EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-021 in_ready SHALL equal (state != FULL), driven from registered state only, no combinational path from out_ready.
REQ-022 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-023 Transitions: EMPTY+push->ONE; ONE+push-pop->FULL; ONE+pop-push->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-024 Latency SHALL be one cycle: an entry pushed in cycle N is visible on out_a/out_b with out_valid=1 in cycle N+1.
REQ-025 out_valid SHALL equal (state != EMPTY); out_a/out_b SHALL always present the oldest entry.
REQ-026 In FULL, in_valid SHALL be ignored and no data overwritten.
REQ-027 With out_valid=1 and out_ready=0, out_a/out_b SHALL remain stable.
REQ-028 flush SHALL force EMPTY next cycle, overriding any simultaneous push or pop; flushed entries are never presented.
REQ-029 occupancy SHALL mirror state encoding 0/1/2; value 3 SHALL never occur.

Reset
REQ-030 rst SHALL force EMPTY, out_valid=0, occupancy=0, out_a=0, out_b=0, sel_err=0 on the next edge.
REQ-031 rst SHALL override flush, push and pop; rst mid-transfer discards all entries.
REQ-032 During rst cycle, in_ready SHALL reflect the pre-reset state; from the first cycle after, in_ready=1.

Configuration
REQ-033 Macro ALU_SRC_STAGE_SEL_ERR_EN defined: sel_err SHALL set on any push where a_sel or b_sel >= NSRC and hold until rst.
REQ-034 Macro ALU_SRC_STAGE_SEL_ERR_EN undefined: sel_err SHALL be constant 0 and no error register SHALL exist; selection behaviour unchanged.

Verification (WIDTH=32, NSRC=5, SEL_W=3)
REQ-035 src words 0..4 = 0x10,0x20,0x30,0x40,0x50; push a_sel=2,b_sel=4, out_ready=1 -> next cycle out_valid=1, out_a=0x30, out_b=0x50, occupancy=1.
REQ-036 out_ready=0, push three entries (sel 0/1, 1/2, 3/4) -> in_ready=0 after second; third rejected; pops then yield 0x10/0x20, 0x20/0x30 in order, occupancy 2->1->0.
REQ-037 occupancy=1, push and pop same cycle -> occupancy stays 1, out_a/out_b switch to new entry.
REQ-038 push a_sel=6,b_sel=1 -> out_a=0, out_b=0x20; sel_err=1 with macro, 0 without; sel_err stays 1 after later valid pushes.
REQ-039 occupancy=2, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1.
REQ-040 occupancy=2, sel_err=1, assert rst with flush and in_valid -> next cycle all outputs 0, in_ready=1.
